// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares one pipelined memory port between an I-cache (block fills only)
//   and a D-cache (block fills or single-word writes).
//
//   Handshake: a requester raises *_req (with its address/data stable) and
//   holds it until it sees its one-cycle *_done pulse. The grant covers the
//   whole access and is never preempted. Memory accepts one mem_en per cycle
//   and answers every read exactly LATENCY cycles later with mem_valid.
//
//   Ports
//     clk, rst                         clock, synchronous active-high reset
//     i_req, i_addr                    I-cache fill request
//     d_req, d_write, d_addr, d_wdata  D-cache fill/write request
//     mem_en, mem_wr, mem_addr, mem_wdata, mem_rdata, mem_valid   memory side
//     i_grant, d_grant                 current owner of the memory port
//     fill_data, fill_valid, fill_word returned fill words (registered)
//     i_done, d_done                   completion pulses
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter  int LATENCY = 4,
  parameter  int WORDS   = 8,
  localparam int WB      = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [15:0]   i_addr,
  input  logic          d_req,
  input  logic          d_write,
  input  logic [15:0]   d_addr,
  input  logic [15:0]   d_wdata,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [15:0]   mem_addr,
  output logic [15:0]   mem_wdata,
  input  logic [15:0]   mem_rdata,
  input  logic          mem_valid,
  output logic          i_grant,
  output logic          d_grant,
  output logic [15:0]   fill_data,
  output logic          fill_valid,
  output logic [WB-1:0] fill_word,
  output logic          i_done,
  output logic          d_done
);

  localparam int DW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [2:0] {DRAIN, IDLE, IFILL, DFILL, DWRITE} state_t;

  state_t          state_q, state_d;
  logic [WB:0]     issue_cnt_q, issue_cnt_d;
  logic [WB:0]     rcv_cnt_q, rcv_cnt_d;
  logic [DW-1:0]   drain_cnt_q, drain_cnt_d;
  logic            d_first_q, d_first_d;   // D wins the next simultaneous request
  logic            i_done_q, i_done_d;
  logic            d_done_q, d_done_d;
  logic            fill_valid_q, fill_valid_d;
  logic [WB-1:0]   fill_word_q, fill_word_d;
  logic [15:0]     fill_data_q, fill_data_d;

  logic            mem_en_c, mem_wr_c;
  logic [15:0]     mem_addr_c, mem_wdata_c;
  logic            i_ok, d_ok, pick_d;
  logic [15:0]     fill_addr;

  always_comb begin
    state_d      = state_q;
    issue_cnt_d  = issue_cnt_q;
    rcv_cnt_d    = rcv_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    d_first_d    = d_first_q;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;
    fill_valid_d = 1'b0;
    fill_word_d  = fill_word_q;
    fill_data_d  = fill_data_q;
    mem_en_c     = 1'b0;
    mem_wr_c     = 1'b0;
    mem_addr_c   = '0;
    mem_wdata_c  = '0;

    // A requester whose done pulse is showing still has req high this cycle;
    // it must not be mistaken for a fresh request.
    i_ok      = i_req & ~i_done_q;
    d_ok      = d_req & ~d_done_q;
    pick_d    = (i_ok & d_ok) ? d_first_q : d_ok;
    fill_addr = (state_q == DFILL) ? d_addr : i_addr;

    case (state_q)
      DRAIN: begin
        // Let reads that were in flight at reset come back and be dropped.
        if (drain_cnt_q == DW'(LATENCY - 1)) state_d = IDLE;
        else                                 drain_cnt_d = drain_cnt_q + 1'b1;
      end
      IDLE: begin
        if (i_ok | d_ok) begin
          issue_cnt_d = '0;
          rcv_cnt_d   = '0;
          if (i_ok & d_ok) d_first_d = ~d_first_q;
          if (pick_d) state_d = d_write ? DWRITE : DFILL;
          else        state_d = IFILL;
        end
      end
      IFILL, DFILL: begin
        if (issue_cnt_q < (WB+1)'(WORDS)) begin
          mem_en_c    = 1'b1;
          mem_addr_c  = {fill_addr[15:WB+1], issue_cnt_q[WB-1:0], 1'b0};
          issue_cnt_d = issue_cnt_q + 1'b1;
        end
        if (mem_valid && (rcv_cnt_q < (WB+1)'(WORDS))) begin
          fill_valid_d = 1'b1;
          fill_word_d  = rcv_cnt_q[WB-1:0];
          fill_data_d  = mem_rdata;
          rcv_cnt_d    = rcv_cnt_q + 1'b1;
          if (rcv_cnt_q == (WB+1)'(WORDS - 1)) begin
            state_d = IDLE;
            if (state_q == IFILL) i_done_d = 1'b1;
            else                  d_done_d = 1'b1;
          end
        end
      end
      DWRITE: begin
        mem_en_c    = 1'b1;
        mem_wr_c    = 1'b1;
        mem_addr_c  = d_addr;
        mem_wdata_c = d_wdata;
        d_done_d    = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = DRAIN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= DRAIN;
      issue_cnt_q  <= '0;
      rcv_cnt_q    <= '0;
      drain_cnt_q  <= '0;
      d_first_q    <= 1'b1;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      fill_valid_q <= 1'b0;
      fill_word_q  <= '0;
      fill_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      issue_cnt_q  <= issue_cnt_d;
      rcv_cnt_q    <= rcv_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      d_first_q    <= d_first_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
      fill_valid_q <= fill_valid_d;
      fill_word_q  <= fill_word_d;
      fill_data_q  <= fill_data_d;
    end
  end

  // Outputs are forced low while rst is high, including the cycle before the
  // first reset edge, so an aborted access stops driving memory immediately.
  assign mem_en     = mem_en_c & ~rst;
  assign mem_wr     = mem_wr_c & ~rst;
  assign mem_addr   = rst ? '0 : mem_addr_c;
  assign mem_wdata  = rst ? '0 : mem_wdata_c;
  assign i_grant    = ~rst & (state_q == IFILL);
  assign d_grant    = ~rst & ((state_q == DFILL) | (state_q == DWRITE));
  assign fill_valid = ~rst & fill_valid_q;
  assign fill_word  = rst ? '0 : fill_word_q;
  assign fill_data  = rst ? '0 : fill_data_q;
  assign i_done     = ~rst & i_done_q;
  assign d_done     = ~rst & d_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Drives two requesters and a fixed-latency memory, and predicts every
//   output per cycle from a transaction-level model: each granted access is a
//   record (kind, grant cycle, address) from which issue slots, return slots,
//   fill words and the done cycle follow by arithmetic.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
  localparam int L  = 4;
  localparam int W  = 8;
  localparam int WB = 3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          i_req, d_req, d_write;
  logic [15:0]   i_addr, d_addr, d_wdata;
  logic          mem_en, mem_wr;
  logic [15:0]   mem_addr, mem_wdata, mem_rdata;
  logic          mem_valid;
  logic          i_grant, d_grant;
  logic [15:0]   fill_data;
  logic          fill_valid;
  logic [WB-1:0] fill_word;
  logic          i_done, d_done;

  mem_arbiter #(.LATENCY(L), .WORDS(W)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .i_grant(i_grant), .d_grant(d_grant),
    .fill_data(fill_data), .fill_valid(fill_valid), .fill_word(fill_word),
    .i_done(i_done), .d_done(d_done)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // staged stimulus, applied at the next falling edge
  int          rst_hold = 0;
  bit          i_raise = 0, d_raise = 0, i_drop = 0, d_drop = 0, rand_mode = 0;
  logic [15:0] i_addr_s, d_addr_s, d_wdata_s;
  logic        d_write_s;

  // memory model: outstanding reads
  int          rd_due[$];
  logic [15:0] rd_addr[$];

  // reference model
  bit          tx_on = 0;
  int          tx_kind = 0;        // 0 I fill, 1 D fill, 2 D write
  int          tx_g = 0, tx_end = 0;
  logic [15:0] tx_addr = '0, tx_wdata = '0;
  bit          tie_d = 1;
  int          free_at = 0;
  logic [WB+15:0] exp_q[$];

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'd3) ^ 16'h5A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic raise_i(input logic [15:0] a);
    i_raise = 1; i_addr_s = a;
  endtask

  task automatic raise_d(input logic w, input logic [15:0] a, input logic [15:0] wd);
    d_raise = 1; d_write_s = w; d_addr_s = a; d_wdata_s = wd;
  endtask

  task automatic step();
    bit e_ig, e_dg, e_en, e_wr, e_fv, e_id, e_dd, fill_busy, i_ok, d_ok, pick_d, in_rst;
    logic [15:0] e_addr, e_wdata;
    logic [WB+15:0] e_fill;
    int k;
    @(negedge clk);
    cyc++;
    in_rst = (rst_hold > 0);
    if (rst_hold > 0) rst_hold--;
    rst = in_rst;
    if (i_drop || in_rst) begin i_req = 0; i_drop = 0; end
    if (d_drop || in_rst) begin d_req = 0; d_drop = 0; end
    if (i_raise && !in_rst) begin i_req = 1; i_addr = i_addr_s; end
    if (d_raise && !in_rst) begin
      d_req = 1; d_write = d_write_s; d_addr = d_addr_s; d_wdata = d_wdata_s;
    end
    i_raise = 0; d_raise = 0;

    {e_ig, e_dg, e_en, e_wr, e_fv, e_id, e_dd, fill_busy} = '0;
    e_addr = '0; e_wdata = '0; e_fill = '0;
    if (in_rst) begin
      tx_on = 0; tie_d = 1; free_at = cyc + L + 1; exp_q.delete();
    end else begin
      if (tx_on && cyc >= tx_g) begin
        k = cyc - tx_g;
        if (cyc == tx_end) begin e_id = (tx_kind == 0); e_dd = (tx_kind != 0); end
        else begin e_ig = (tx_kind == 0); e_dg = (tx_kind != 0); end
        if (tx_kind == 2) begin
          if (k == 0) begin e_en = 1; e_wr = 1; e_addr = tx_addr; e_wdata = tx_wdata; end
        end else begin
          if (k < W) begin e_en = 1; e_addr = (tx_addr & ~16'(2*W-1)) | 16'(2*k); end
          if (k >= L + 1 && k <= L + W && exp_q.size() > 0) begin e_fv = 1; e_fill = exp_q.pop_front(); end
          fill_busy = (k < W + L);
        end
        if (cyc == tx_end) tx_on = 0;
      end
      if (!tx_on && cyc >= free_at) begin
        i_ok = i_req && !e_id;
        d_ok = d_req && !e_dd;
        if (i_ok || d_ok) begin
          pick_d = (i_ok && d_ok) ? tie_d : d_ok;
          if (i_ok && d_ok) tie_d = !tie_d;
          tx_on = 1; tx_g = cyc + 1;
          if (pick_d) begin tx_kind = d_write ? 2 : 1; tx_addr = d_addr; tx_wdata = d_wdata; end
          else begin tx_kind = 0; tx_addr = i_addr; tx_wdata = '0; end
          tx_end = tx_g + ((tx_kind == 2) ? 1 : W + L);
          if (tx_kind != 2)
            for (int j = 0; j < W; j++) begin
              logic [15:0] a;
              a = (tx_addr & ~16'(2*W-1)) | 16'(2*j);
              exp_q.push_back({WB'(j), mem_word(a)});
            end
        end
      end
    end

    // memory returns, plus stray mem_valid pulses whenever no fill is running
    if (rd_due.size() > 0 && rd_due[0] == cyc) begin
      mem_valid = 1; mem_rdata = mem_word(rd_addr[0]);
      void'(rd_due.pop_front()); void'(rd_addr.pop_front());
    end else if (!fill_busy && $urandom_range(0, 3) == 0) begin
      mem_valid = 1; mem_rdata = 16'($urandom);
    end else begin
      mem_valid = 0; mem_rdata = 16'($urandom);
    end

    #1;
    check("mem_en", 32'(mem_en), 32'(e_en));
    check("mem_wr", 32'(mem_wr), 32'(e_wr));
    check("i_grant", 32'(i_grant), 32'(e_ig));
    check("d_grant", 32'(d_grant), 32'(e_dg));
    check("grant_excl", 32'(i_grant & d_grant), 32'(0));
    check("fill_valid", 32'(fill_valid), 32'(e_fv));
    check("i_done", 32'(i_done), 32'(e_id));
    check("d_done", 32'(d_done), 32'(e_dd));
    if (e_en) check("mem_addr", 32'(mem_addr), 32'(e_addr));
    if (e_wr) check("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    if (e_fv) begin
      check("fill_word", 32'(fill_word), 32'(e_fill[WB+15:16]));
      check("fill_data", 32'(fill_data), 32'(e_fill[15:0]));
    end
    if (in_rst) begin
      check("rst_mem_addr", 32'(mem_addr), 32'(0));
      check("rst_fill_data", 32'(fill_data), 32'(0));
      check("rst_fill_word", 32'(fill_word), 32'(0));
    end

    if (mem_en && !mem_wr) begin rd_due.push_back(cyc + L); rd_addr.push_back(mem_addr); end
    if (i_done) i_drop = 1;
    if (d_done) d_drop = 1;

    if (rand_mode) begin
      if (!i_req && !i_drop && $urandom_range(0, 5) == 0) raise_i(16'($urandom));
      if (!d_req && !d_drop && $urandom_range(0, 5) == 0)
        raise_d(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      if (rst_hold == 0 && $urandom_range(0, 299) == 0) rst_hold = $urandom_range(1, 2);
    end
  endtask

  task automatic wait_quiet(input int budget);
    int n = 0;
    while ((i_req || d_req || i_raise || d_raise || tx_on || rst_hold > 0) && n < budget) begin
      step(); n++;
    end
    if (n >= budget) begin
      vectors++; miscompares++;
      $display("FAIL wait_quiet: still busy after %0d cycles, required idle", budget);
    end
  endtask

  task automatic wait_i_grant(input int budget);
    int n = 0;
    while (!i_grant && n < budget) begin step(); n++; end
    if (n >= budget) begin
      vectors++; miscompares++;
      $display("FAIL wait_i_grant: i_grant 0 after %0d cycles, required 1", budget);
    end
  endtask

  initial begin
    rst = 1; i_req = 0; d_req = 0; d_write = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    mem_valid = 0; mem_rdata = '0;

    rst_hold = 3;
    repeat (3) step();

    // single I fill at 0x1234 -> 0x1230..0x123E
    raise_i(16'h1234);
    wait_quiet(100);

    // single D write
    raise_d(1'b1, 16'h0040, 16'hBEEF);
    wait_quiet(100);

    // simultaneous requests: D first, then I; again: I first, then D
    raise_i(16'h4100); raise_d(1'b0, 16'h8200, 16'h0000);
    wait_quiet(200);
    raise_i(16'h4300); raise_d(1'b0, 16'h8400, 16'h0000);
    wait_quiet(200);

    // D request arrives during an I fill
    raise_i(16'h1111);
    wait_i_grant(50);
    repeat (2) step();
    raise_d(1'b0, 16'h2222, 16'h0000);
    wait_quiet(200);

    // reset after three fill issues, then a clean fill
    raise_i(16'h2000);
    wait_i_grant(50);
    repeat (2) step();
    rst_hold = 1;
    repeat (L + 3) step();
    raise_i(16'h3456);
    wait_quiet(100);

    // randomized traffic with occasional resets
    rand_mode = 1;
    repeat (1500) step();
    rand_mode = 0;
    wait_quiet(300);
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
